// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead add/subtract unit.
package cla_pkg;
  localparam int unsigned WIDTH = 16;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cb;
    logic             ovf;
    logic             zero;
  } result_t;
endpackage

// File: rtl/cla_addsub_pipe_cla.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a lookahead carry unit.
module CLA_16bit_withLCU (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] p;
  logic [15:0] g;
  logic [15:0] c;
  logic [3:0]  gp;
  logic [3:0]  gg;
  logic [4:0]  gc;

  assign p = a ^ b;
  assign g = a & b;

  always_comb begin
    gp = '0;
    gg = '0;
    for (int i = 0; i < 4; i++) begin
      gp[i] = &p[4*i +: 4];
      gg[i] = g[4*i+3]
            | (p[4*i+3] & g[4*i+2])
            | (p[4*i+3] & p[4*i+2] & g[4*i+1])
            | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
    end
  end

  // Group carries are fully expanded so no carry ripples between groups.
  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  always_comb begin
    c = '0;
    for (int i = 0; i < 4; i++) begin
      c[4*i]   = gc[i];
      c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
      c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
      c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
               | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
    end
  end

  assign sum  = p ^ c;
  assign cout = gc[4];
endmodule

// File: rtl/cla_addsub_pipe.sv
// Two-stage valid/ready add/subtract pipeline around CLA_16bit_withLCU with carry/borrow,
// overflow and zero flags plus a delivered-results counter.
module cla_addsub_pipe
  import cla_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_cb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cb,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_count
);
  logic             s1_valid;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_eff_q;
  logic             c_eff_q;
  logic             op_q;
  logic [WIDTH-1:0] cla_sum;
  logic             cla_cout;
  logic             adv;
  result_t          res;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = ~rst & (~s1_valid | adv);

  CLA_16bit_withLCU u_cla (
    .a    (a_q),
    .b    (b_eff_q),
    .cin  (c_eff_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Subtraction already arrives as A + ~B + ~bin, so overflow uses the effective operands.
  always_comb begin
    res.sum  = cla_sum;
    res.cb   = (op_q == OP_SUB) ? ~cla_cout : cla_cout;
    res.ovf  = (a_q[WIDTH-1] == b_eff_q[WIDTH-1]) & (cla_sum[WIDTH-1] != a_q[WIDTH-1]);
    res.zero = (cla_sum == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      a_q      <= '0;
      b_eff_q  <= '0;
      c_eff_q  <= 1'b0;
      op_q     <= OP_ADD;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      a_q      <= in_a;
      b_eff_q  <= (in_op == OP_SUB) ? ~in_b : in_b;
      c_eff_q  <= (in_op == OP_SUB) ? ~in_cb : in_cb;
      op_q     <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cb    <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b1;
    end else if (adv) begin
      out_valid <= s1_valid;
      out_sum   <= res.sum;
      out_cb    <= res.cb;
      out_ovf   <= res.ovf;
      out_zero  <= res.zero;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_count <= '0;
    end else if (out_valid & out_ready) begin
      out_count <= out_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed self-checking bench for cla_addsub_pipe.
module tb_cla_addsub_pipe;
  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        in_op;
  logic        in_cb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_sum;
  logic        out_cb;
  logic        out_ovf;
  logic        out_zero;
  logic [15:0] out_count;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_cnt = 16'h0000;

  cla_addsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_cb     (in_cb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cb    (out_cb),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero),
    .out_count (out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_cb = 1'b0;
    out_ready = 1'b1;
    next_cycle(); next_cycle();
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready_hi got=%b exp=0", in_ready);
    end
    n_tests++;
    if ({out_valid, out_sum, out_cb, out_ovf, out_zero} !== {1'b0, 16'h0000, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b sum=%h cb=%b ovf=%b z=%b exp v=0 sum=0000 cb=0 ovf=0 z=1",
               out_valid, out_sum, out_cb, out_ovf, out_zero);
    end
    n_tests++;
    if (out_count !== 16'h0000) begin
      n_fail++; $display("FAIL reset_count got=%h exp=0000", out_count);
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", in_ready);
    end
    exp_cnt = 16'h0000;
  endtask

  // One beat into an empty pipe with out_ready held high; checks latency and all flags.
  task automatic send_one(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic op, input logic cb, input logic [15:0] e_sum,
                          input logic e_cb, input logic e_ovf, input logic e_zero);
    out_ready = 1'b1;
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op; in_cb = cb;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s_in_ready got=%b exp=1", name, in_ready);
    end
    next_cycle();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL %s_early_valid got=%b exp=0", name, out_valid);
    end
    next_cycle();
    n_tests++;
    if ({out_valid, out_sum, out_cb, out_ovf, out_zero} !== {1'b1, e_sum, e_cb, e_ovf, e_zero}) begin
      n_fail++;
      $display("FAIL %s_result got v=%b sum=%h cb=%b ovf=%b z=%b exp v=1 sum=%h cb=%b ovf=%b z=%b",
               name, out_valid, out_sum, out_cb, out_ovf, out_zero, e_sum, e_cb, e_ovf, e_zero);
    end
    next_cycle();
    exp_cnt = exp_cnt + 16'h0001;
    n_tests++;
    if (out_count !== exp_cnt || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_count got cnt=%h v=%b exp cnt=%h v=0", name, out_count, out_valid, exp_cnt);
    end
  endtask

  task automatic test_add();
    send_one("add", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    send_one("add_cin", 16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_sub();
    send_one("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
    send_one("sub_bin", 16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    send_one("sub_equal", 16'hABCD, 16'hABCD, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_flags();
    send_one("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    send_one("carry_zero", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send_one("ovf_sub", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_pressure();
    int acc;
    int del;
    int cyc;
    acc = 0; del = 0;
    for (cyc = 0; cyc < 40 && del < 6; cyc++) begin
      out_ready = (cyc >= 5);
      in_valid = (acc < 6); in_a = 16'(acc); in_b = 16'h0100; in_op = 1'b0; in_cb = 1'b0;
      #1;
      if (cyc >= 2 && cyc < 5) begin
        n_tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 16'h0100) begin
          n_fail++;
          $display("FAIL bp_stall_cyc%0d got rdy=%b v=%b sum=%h exp rdy=0 v=1 sum=0100",
                   cyc, in_ready, out_valid, out_sum);
        end
      end
      if (cyc == 5) begin
        n_tests++;
        if (acc !== 2) begin
          n_fail++; $display("FAIL bp_accepted got=%0d exp=2", acc);
        end
      end
      if (out_valid && out_ready) begin
        n_tests++;
        if (out_sum !== 16'h0100 + 16'(del)) begin
          n_fail++; $display("FAIL bp_order_%0d got=%h exp=%h", del, out_sum, 16'h0100 + 16'(del));
        end
        del++;
      end
      if (in_valid && in_ready) acc++;
      next_cycle();
    end
    in_valid = 1'b0;
    exp_cnt = exp_cnt + 16'(del);
    n_tests++;
    if (del !== 6 || cyc !== 11) begin
      n_fail++; $display("FAIL bp_throughput got del=%0d cyc=%0d exp del=6 cyc=11", del, cyc);
    end
    n_tests++;
    if (out_count !== exp_cnt) begin
      n_fail++; $display("FAIL bp_count got=%h exp=%h", out_count, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 16'h1111; in_b = 16'h2222; in_op = 1'b0; in_cb = 1'b0;
    next_cycle();
    next_cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rmid_pre got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready);
    end
    next_cycle();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out_count !== 16'h0000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_after got v=%b cnt=%h rdy=%b exp v=0 cnt=0000 rdy=1",
               out_valid, out_count, in_ready);
    end
    exp_cnt = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      n_tests++;
      if (out_valid !== 1'b0 || out_count !== 16'h0000) begin
        n_fail++; $display("FAIL rmid_stale_%0d got v=%b cnt=%h exp v=0 cnt=0000", i, out_valid, out_count);
      end
    end
  endtask

  task automatic test_count_wrap();
    int acc;
    int del;
    int cyc;
    acc = 0; del = 0; cyc = 0;
    out_ready = 1'b1; in_b = 16'h0000; in_op = 1'b0; in_cb = 1'b0;
    while (del < 65536 && cyc < 70000) begin
      in_valid = (acc < 65536); in_a = 16'(acc);
      #1;
      if (out_valid && out_ready) del++;
      if (in_valid && in_ready) acc++;
      next_cycle();
      cyc++;
      if (del == 65535) begin
        n_tests++;
        if (out_count !== 16'hFFFF) begin
          n_fail++; $display("FAIL wrap_ffff got=%h exp=ffff", out_count);
        end
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (del !== 65536 || out_count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero got del=%0d cnt=%h exp del=65536 cnt=0000", del, out_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_flags();
    test_back_pressure();
    test_reset_mid();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
